// File: rtl/connect_n_board_engine_if.sv
// Drop-request / move-result bundle between the game FSM and the
// Connect-N board engine.
//
// Valid/ready: a drop transfers on a rising clk edge where drop_valid and
// drop_ready are both high. drop_col and drop_player are sampled only on
// that edge. The master may hold drop_valid high while drop_ready is low.
// result_valid is a single-cycle pulse with no back-pressure. There is
// exactly one pulse per accepted drop. result_placed/row/win/draw keep
// their values between pulses.
//
// Signals:
//   drop_valid, drop_col, drop_player  master -> engine  drop request
//   drop_ready                         engine -> master  engine can accept
//   result_valid                       engine -> master  1-cycle result pulse
//   result_placed/row/win/draw         engine -> master  outcome of the drop
interface connect_n_board_engine_if #(
  parameter int ROWS = 6,
  parameter int COLS = 7
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);

  logic          drop_valid;
  logic          drop_ready;
  logic [CW-1:0] drop_col;
  logic          drop_player;
  logic          result_valid;
  logic          result_placed;
  logic [RW-1:0] result_row;
  logic          result_win;
  logic          result_draw;

  modport master (
    output drop_valid, drop_col, drop_player,
    input  drop_ready, result_valid, result_placed, result_row,
           result_win, result_draw
  );

  modport slave (
    input  drop_valid, drop_col, drop_player,
    output drop_ready, result_valid, result_placed, result_row,
           result_win, result_draw
  );
endinterface

// File: rtl/connect_n_board_engine.sv
// Connect-N board store and move resolver.
// A drop request is accepted through drop_if. Gravity then places the piece
// in the lowest free row of the requested column. The engine walks the four
// line directions through the new cell, one cell per cycle, and reports a
// win, a draw or a rejection as a single result pulse.
//
// Ports:
//   clk, rstn    clock, asynchronous active-low reset
//   clear        synchronous board clear; overrides everything else
//   drop_if      slave side of connect_n_board_engine_if (drop + result)
//   game_over    sticky after a win or a draw until clear/reset
//   col_full     bit c set when column c holds ROWS pieces
//   board_flat   cell (r,c) at [2*(r*COLS+c)+:2]; 00 empty, 01 P0, 10 P1
//   state_dbg    current FSM state (IDLE=0, PLACE=1, CHECK=2, REPORT=3)
module connect_n_board_engine #(
  parameter int ROWS    = 6,
  parameter int COLS    = 7,
  parameter int WIN_LEN = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    clear,
  connect_n_board_engine_if.slave drop_if,
  output logic                    game_over,
  output logic [COLS-1:0]         col_full,
  output logic [ROWS*COLS*2-1:0]  board_flat,
  output logic [1:0]              state_dbg
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int KW = $clog2(WIN_LEN + 1);
  localparam int BW = ROWS * COLS * 2;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_PLACE  = 2'd1;
  localparam logic [1:0] S_CHECK  = 2'd2;
  localparam logic [1:0] S_REPORT = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] board_q, board_d;
  logic [RW:0]   height_q [COLS];
  logic [RW:0]   height_d [COLS];
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [1:0]    code_q, code_d;
  logic [1:0]    dir_q, dir_d;    // 0 H, 1 V, 2 diagonal, 3 anti-diagonal
  logic          side_q, side_d;  // 0 walks the + side, 1 walks the - side
  logic [KW-1:0] k_q, k_d;        // step distance from the new cell
  logic [KW-1:0] cnt_q, cnt_d;    // run length in the current direction
  logic          placed_q, placed_d;
  logic [RW-1:0] res_row_q, res_row_d;
  logic          win_q, win_d;
  logic          draw_q, draw_d;
  logic          over_q, over_d;

  logic accept, bad_drop, hit, in_bounds, done, done_win, board_full;
  int   dr, dc, pr, pc, idx;

  always_comb begin
    for (int c = 0; c < COLS; c++) col_full[c] = (int'(height_q[c]) == ROWS);
  end

  assign board_full = &col_full;
  assign drop_if.drop_ready = (state_q == S_IDLE) && !clear;
  assign accept   = drop_if.drop_valid && drop_if.drop_ready;
  // The column range test comes first, so col_full is only read in range.
  assign bad_drop = (int'(drop_if.drop_col) >= COLS) || over_q ||
                    col_full[drop_if.drop_col];

  // Probe the cell at distance k_q from the new cell. Plain signed integer
  // arithmetic keeps an off-board step from wrapping into a neighbouring row.
  always_comb begin
    dr = (dir_q == 2'd0) ? 0 : 1;
    dc = (dir_q == 2'd1) ? 0 : ((dir_q == 2'd3) ? -1 : 1);
    if (side_q) begin
      dr = -dr;
      dc = -dc;
    end
    pr = int'(row_q) + dr * int'(k_q);
    pc = int'(col_q) + dc * int'(k_q);
    in_bounds = (pr >= 0) && (pr < ROWS) && (pc >= 0) && (pc < COLS);
    idx = in_bounds ? (pr * COLS + pc) : 0;
    hit = in_bounds && (board_q[2*idx +: 2] == code_q);
  end

  always_comb begin
    state_d   = state_q;
    board_d   = board_q;
    height_d  = height_q;
    col_d     = col_q;
    row_d     = row_q;
    code_d    = code_q;
    dir_d     = dir_q;
    side_d    = side_q;
    k_d       = k_q;
    cnt_d     = cnt_q;
    placed_d  = placed_q;
    res_row_d = res_row_q;
    win_d     = win_q;
    draw_d    = draw_q;
    over_d    = over_q;
    done      = 1'b0;
    done_win  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          col_d  = drop_if.drop_col;
          code_d = drop_if.drop_player ? 2'b10 : 2'b01;
          if (bad_drop) begin
            placed_d  = 1'b0;
            res_row_d = '0;
            win_d     = 1'b0;
            draw_d    = 1'b0;
            state_d   = S_REPORT;
          end else begin
            row_d   = height_q[drop_if.drop_col][RW-1:0];
            state_d = S_PLACE;
          end
        end
      end
      S_PLACE: begin
        board_d[2*(int'(row_q)*COLS + int'(col_q)) +: 2] = code_q;
        height_d[col_q] = height_q[col_q] + 1'b1;
        dir_d   = 2'd0;
        side_d  = 1'b0;
        k_d     = KW'(1);
        cnt_d   = KW'(1);
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (hit && (int'(cnt_q) + 1 >= WIN_LEN)) begin
          done     = 1'b1;
          done_win = 1'b1;
        end else if (hit && (int'(k_q) < WIN_LEN - 1)) begin
          cnt_d = cnt_q + 1'b1;
          k_d   = k_q + 1'b1;
        end else begin
          // This side is finished: a miss, the board edge, or the step limit.
          if (hit) cnt_d = cnt_q + 1'b1;
          if (!side_q) begin
            side_d = 1'b1;
            k_d    = KW'(1);
          end else if (dir_q != 2'd3) begin
            dir_d  = dir_q + 2'd1;
            side_d = 1'b0;
            k_d    = KW'(1);
            cnt_d  = KW'(1);
          end else begin
            done = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;  // S_REPORT lasts exactly one cycle
    endcase

    if (done) begin
      placed_d  = 1'b1;
      res_row_d = row_q;
      win_d     = done_win;
      draw_d    = !done_win && board_full;
      over_d    = over_q || done_win || board_full;
      state_d   = S_REPORT;
    end

    if (clear) begin
      state_d   = S_IDLE;
      board_d   = '0;
      for (int c = 0; c < COLS; c++) height_d[c] = '0;
      placed_d  = 1'b0;
      res_row_d = '0;
      win_d     = 1'b0;
      draw_d    = 1'b0;
      over_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      board_q   <= '0;
      for (int c = 0; c < COLS; c++) height_q[c] <= '0;
      col_q     <= '0;
      row_q     <= '0;
      code_q    <= '0;
      dir_q     <= '0;
      side_q    <= 1'b0;
      k_q       <= '0;
      cnt_q     <= '0;
      placed_q  <= 1'b0;
      res_row_q <= '0;
      win_q     <= 1'b0;
      draw_q    <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      board_q   <= board_d;
      height_q  <= height_d;
      col_q     <= col_d;
      row_q     <= row_d;
      code_q    <= code_d;
      dir_q     <= dir_d;
      side_q    <= side_d;
      k_q       <= k_d;
      cnt_q     <= cnt_d;
      placed_q  <= placed_d;
      res_row_q <= res_row_d;
      win_q     <= win_d;
      draw_q    <= draw_d;
      over_q    <= over_d;
    end
  end

  assign drop_if.result_valid  = (state_q == S_REPORT);
  assign drop_if.result_placed = placed_q;
  assign drop_if.result_row    = res_row_q;
  assign drop_if.result_win    = win_q;
  assign drop_if.result_draw   = draw_q;
  assign game_over  = over_q;
  assign board_flat = board_q;
  assign state_dbg  = state_q;
endmodule

// File: tb/tb_connect_n_board_engine.sv
`timescale 1ns/1ps
module tb_connect_n_board_engine;
  localparam int ROWS    = 6;
  localparam int COLS    = 7;
  localparam int WIN_LEN = 4;
  localparam int CW      = $clog2(COLS);
  localparam int RW      = $clog2(ROWS);
  localparam int BW      = ROWS * COLS * 2;
  // Cycles from the first cycle after the accept edge to the result pulse.
  localparam int LAT_MAX = 2 + 8 * (WIN_LEN - 1);

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rstn  = 1'b0;
  logic clear = 1'b0;
  logic            game_over;
  logic [COLS-1:0] col_full;
  logic [BW-1:0]   board_flat;
  logic [1:0]      state_dbg;

  always #5 clk = ~clk;

  connect_n_board_engine_if #(.ROWS(ROWS), .COLS(COLS)) dif ();

  connect_n_board_engine #(.ROWS(ROWS), .COLS(COLS), .WIN_LEN(WIN_LEN)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .clear      (clear),
    .drop_if    (dif),
    .game_over  (game_over),
    .col_full   (col_full),
    .board_flat (board_flat),
    .state_dbg  (state_dbg)
  );

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic            placed;
    logic [RW-1:0]   row;
    logic            win;
    logic            draw;
    logic            go;
    logic [COLS-1:0] full;
    logic [BW-1:0]   board;
  } exp_t;
  localparam int EW = $bits(exp_t);

  int mb [ROWS][COLS];
  int mh [COLS];
  bit mgo;

  function automatic void model_reset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) mb[r][c] = 0;
    for (int c = 0; c < COLS; c++) mh[c] = 0;
    mgo = 1'b0;
  endfunction

  // Longest run of `code` through (r,c) along (dr,dc), walking to the board edge.
  function automatic int run_len(int r, int c, int dr, int dc, int code);
    int n, rr, cc;
    n = 1;
    for (int s = -1; s <= 1; s += 2) begin
      rr = r + s * dr;
      cc = c + s * dc;
      while (rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS && mb[rr][cc] == code) begin
        n++;
        rr += s * dr;
        cc += s * dc;
      end
    end
    return n;
  endfunction

  function automatic exp_t model_drop(int col, int player);
    exp_t e;
    int   code, r;
    bit   full;
    e = '0;
    code = player + 1;
    if (!(col >= COLS || mgo || mh[col] == ROWS)) begin
      r = mh[col];
      mb[r][col] = code;
      mh[col]++;
      e.placed = 1'b1;
      e.row    = RW'(r);
      e.win    = (run_len(r, col, 0, 1, code) >= WIN_LEN) ||
                 (run_len(r, col, 1, 0, code) >= WIN_LEN) ||
                 (run_len(r, col, 1, 1, code) >= WIN_LEN) ||
                 (run_len(r, col, 1, -1, code) >= WIN_LEN);
      full = 1'b1;
      for (int c = 0; c < COLS; c++) if (mh[c] != ROWS) full = 1'b0;
      e.draw = !e.win && full;
      mgo = mgo | e.win | e.draw;
    end
    e.go = mgo;
    for (int c = 0; c < COLS; c++) e.full[c] = (mh[c] == ROWS);
    for (int r2 = 0; r2 < ROWS; r2++)
      for (int c = 0; c < COLS; c++) e.board[2*(r2*COLS+c) +: 2] = 2'(mb[r2][c]);
    return e;
  endfunction

  // ---------------- scoreboard ----------------
  logic [EW-1:0]   exp_q[$];
  int              n_cmp = 0;
  int              n_fail = 0;
  int              cyc = 0;
  int              acc_cyc = 0;
  bit              have_last = 1'b0;
  logic [RW+3:0]   last_res;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : compare
    exp_t e;
    int   lat;
    if (rstn) begin
      if (dif.result_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_pulse: got result_valid=1 expected 0 (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          lat = cyc - acc_cyc;
          check("result_placed", dif.result_placed, e.placed);
          check("result_row", dif.result_row, e.row);
          check("result_win", dif.result_win, e.win);
          check("result_draw", dif.result_draw, e.draw);
          check("col_full", col_full, e.full);
          check("board_flat", board_flat, e.board);
          if (!e.placed) check("reject_latency", lat, 0);
          else check("placed_latency_in_range", (lat >= 2 && lat <= LAT_MAX), 1);
          last_res  = {e.placed, e.row, e.win, e.draw, e.go};
          have_last = 1'b1;
        end
      end else if (have_last) begin
        check("result_hold", {dif.result_placed, dif.result_row, dif.result_win,
                              dif.result_draw, game_over}, last_res);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    have_last = 1'b0;
    rstn = 1'b0;
    clear = 1'b0;
    dif.drop_valid = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    exp_q.delete();
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_drop(input int col, input int player);
    exp_t e;
    bit   seen;
    @(negedge clk);
    dif.drop_valid  = 1'b1;
    dif.drop_col    = CW'(col);
    dif.drop_player = player[0];
    check("drop_ready_idle", dif.drop_ready, 1);
    e = model_drop(col, player);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    dif.drop_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < LAT_MAX + 4 && !seen; i++) begin
      @(negedge clk);
      if (dif.result_valid) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL result_timeout: got no pulse expected one within %0d cycles (col %0d)",
               LAT_MAX, col);
      exp_q.delete();
    end
  endtask

  // Start a drop that the model does not track; it is aborted by clear/reset.
  task automatic raw_drop(input int col);
    @(negedge clk);
    dif.drop_valid  = 1'b1;
    dif.drop_col    = CW'(col);
    dif.drop_player = 1'b0;
    @(posedge clk);
    #1;
    dif.drop_valid = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_board"}, board_flat, 0);
    check({tag, "_col_full"}, col_full, 0);
    check({tag, "_game_over"}, game_over, 0);
    check({tag, "_result_valid"}, dif.result_valid, 0);
    check({tag, "_results"}, {dif.result_placed, dif.result_row, dif.result_win,
                              dif.result_draw}, 0);
  endtask

  // ---------------- stimulus ----------------
  logic [BW-1:0] one_cell;

  initial begin : main
    dif.drop_valid  = 1'b0;
    dif.drop_col    = '0;
    dif.drop_player = 1'b0;

    // Reset state
    do_reset();
    check_cleared("reset");
    check("reset_drop_ready", dif.drop_ready, 1);

    // First drop lands at the bottom of column 3
    do_drop(3, 0);
    one_cell = '0;
    one_cell[7:6] = 2'b01;
    check("first_placed", dif.result_placed, 1);
    check("first_row", dif.result_row, 0);
    check("first_win", dif.result_win, 0);
    check("first_board", board_flat, one_cell);

    // Fill column 0, then overflow it
    do_reset();
    for (int i = 0; i < ROWS; i++) do_drop(0, i % 2);
    do_drop(0, 0);
    check("overflow_placed", dif.result_placed, 0);
    check("overflow_col_full", col_full, 7'b0000001);

    // Horizontal win, then a drop after game over is rejected
    do_reset();
    for (int i = 0; i < 3; i++) begin
      do_drop(i, 0);
      do_drop(6, 1);
    end
    do_drop(3, 0);
    check("hwin_win", dif.result_win, 1);
    do_drop(5, 1);
    check("after_win_placed", dif.result_placed, 0);
    check("after_win_game_over", game_over, 1);

    // Runs that would only connect by wrapping across a row boundary
    do_reset();
    do_drop(0, 1);
    do_drop(4, 0);
    do_drop(5, 0);
    do_drop(6, 0);
    do_drop(0, 0);
    check("wrap_right_win", dif.result_win, 0);
    do_reset();
    do_drop(6, 0);
    for (int c = 0; c < 3; c++) do_drop(c, 1);
    for (int c = 0; c < 3; c++) do_drop(c, 0);
    check("wrap_left_win", dif.result_win, 0);

    // Diagonal win for P1
    do_reset();
    do_drop(0, 1); do_drop(1, 0); do_drop(1, 1);
    do_drop(2, 0); do_drop(2, 0); do_drop(2, 1);
    do_drop(3, 0); do_drop(3, 0); do_drop(3, 0); do_drop(3, 1);
    check("diag_win", dif.result_win, 1);
    // Anti-diagonal mirror
    do_reset();
    do_drop(6, 1); do_drop(5, 0); do_drop(5, 1);
    do_drop(4, 0); do_drop(4, 0); do_drop(4, 1);
    do_drop(3, 0); do_drop(3, 0); do_drop(3, 0); do_drop(3, 1);
    check("anti_win", dif.result_win, 1);

    // Clear two cycles into CHECK aborts the drop with no pulse
    do_reset();
    do_drop(1, 0);
    do_drop(1, 1);
    raw_drop(4);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    have_last = 1'b0;
    clear = 1'b1;
    check("ready_low_in_clear", dif.drop_ready, 0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    @(negedge clk);
    check_cleared("clear");
    check("clear_drop_ready", dif.drop_ready, 1);
    repeat (12) @(negedge clk);
    model_reset();

    // Clear and drop_valid together: the drop is not taken
    do_drop(2, 0);
    @(negedge clk);
    have_last = 1'b0;
    clear = 1'b1;
    dif.drop_valid = 1'b1;
    dif.drop_col = 3'd2;
    @(posedge clk);
    #1;
    clear = 1'b0;
    dif.drop_valid = 1'b0;
    repeat (6) @(negedge clk);
    check_cleared("clear_with_drop");
    model_reset();

    // Asynchronous reset in the middle of CHECK
    do_drop(2, 0);
    do_drop(3, 1);
    raw_drop(5);
    @(posedge clk);
    @(posedge clk);
    #2;
    have_last = 1'b0;
    rstn = 1'b0;
    #1;
    check_cleared("async_reset");
    check("async_reset_ready", dif.drop_ready, 1);
    do_reset();

    // Full board with no line of four: last drop is a draw
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++) do_drop(c, ((r / 2) + c) % 2);
    check("draw_draw", dif.result_draw, 1);
    check("draw_win", dif.result_win, 0);
    check("draw_col_full", col_full, 7'b1111111);
    @(negedge clk);
    check("draw_game_over", game_over, 1);

    // Random games, including out-of-range columns
    for (int g = 0; g < 6; g++) begin
      do_reset();
      for (int n = 0; n < 45; n++) do_drop($urandom_range(0, 7), $urandom_range(0, 1));
    end

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    n_cmp++;
    n_fail++;
    $display("FAIL watchdog: got no end of test expected finish before %0t", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
